// File: rtl/axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_strip_header
// Description : Removes a per-packet header of S bytes (0..DATA_BYTE_WD) from
//               the front of an AXI-Stream packet. The removed bytes appear
//               LSB-aligned on header_out. The remaining payload is realigned
//               so that every output beat starts at the MSB byte lane.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               *_in / ready_in    - input stream (byte 0 in the MSB lane)
//               *_out / ready_out  - realigned payload stream
//               valid_strip, byte_strip_cnt, ready_strip - strip command
//               header_out, header_keep, header_valid    - removed header
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    ready_strip,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] header_keep,
    output logic                    header_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STREAM = 2'd2,
        ST_TAIL   = 2'd3
    } state_t;

    localparam logic [BYTE_CNT_WD:0]    c_nbytes   = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] c_keep_all = '1;

    state_t                    r_state, w_state_nxt;
    logic [BYTE_CNT_WD:0]      r_strip_cnt, w_strip_cnt_nxt;
    logic [DATA_WD-1:0]        r_residue, w_residue_nxt;
    logic [BYTE_CNT_WD:0]      r_tail_cnt, w_tail_cnt_nxt;

    logic                      w_valid_out_nxt;
    logic [DATA_WD-1:0]        w_data_out_nxt;
    logic [DATA_BYTE_WD-1:0]   w_keep_out_nxt;
    logic                      w_last_out_nxt;
    logic [DATA_WD-1:0]        w_header_out_nxt;
    logic [DATA_BYTE_WD-1:0]   w_header_keep_nxt;
    logic                      w_header_valid_nxt;

    logic [DATA_WD-1:0]        w_keep_mask;
    logic [DATA_WD-1:0]        w_data_m;
    logic [DATA_WD-1:0]        w_top_s;
    logic [DATA_WD-1:0]        w_low_r;
    logic [DATA_WD-1:0]        w_combined;
    logic [BYTE_CNT_WD:0]      w_in_cnt;
    logic [BYTE_CNT_WD:0]      w_res_cnt;
    logic [BYTE_CNT_WD:0]      w_strip_req;
    logic                      w_out_adv;
    logic                      w_beat_acc;
    logic                      w_strip_acc;

    // The output register may be reloaded when it is empty or being drained.
    assign w_out_adv   = !valid_out || ready_out;
    assign ready_in    = ((r_state == ST_FIRST) || (r_state == ST_STREAM)) && w_out_adv;
    // Gated by rst so the command port reads not-ready while reset is held.
    assign ready_strip = (r_state == ST_IDLE) && !rst;
    assign w_beat_acc  = valid_in && ready_in;
    assign w_strip_acc = valid_strip && ready_strip;

    // Out-of-range strip counts saturate at a full beat.
    assign w_strip_req = (byte_strip_cnt > c_nbytes) ? c_nbytes : byte_strip_cnt;

    // Byte-lane mask from keep_in and the number of valid bytes in the beat.
    // Invalid lanes are zeroed so partial residues never carry stale bytes.
    always_comb begin
        w_keep_mask = '0;
        w_in_cnt    = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            w_keep_mask[8*i +: 8] = {8{keep_in[i]}};
            w_in_cnt              = w_in_cnt + (BYTE_CNT_WD + 1)'(keep_in[i]);
        end
    end

    assign w_data_m   = data_in & w_keep_mask;
    assign w_res_cnt  = c_nbytes - r_strip_cnt;
    // Top S bytes of the beat moved down to the low S lanes.
    assign w_top_s    = w_data_m >> {w_res_cnt, 3'b000};
    // Low R bytes of the beat moved up to the MSB lanes (next residue).
    assign w_low_r    = w_data_m << {r_strip_cnt, 3'b000};
    assign w_combined = r_residue | w_top_s;

    always_comb begin
        w_state_nxt        = r_state;
        w_strip_cnt_nxt    = r_strip_cnt;
        w_residue_nxt      = r_residue;
        w_tail_cnt_nxt     = r_tail_cnt;
        w_valid_out_nxt    = valid_out && !ready_out;
        w_data_out_nxt     = data_out;
        w_keep_out_nxt     = keep_out;
        w_last_out_nxt     = last_out;
        w_header_out_nxt   = header_out;
        w_header_keep_nxt  = header_keep;
        w_header_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_strip_acc) begin
                    w_strip_cnt_nxt = w_strip_req;
                    w_state_nxt     = ST_FIRST;
                end
            end

            ST_FIRST: begin
                if (w_beat_acc) begin
                    w_header_out_nxt   = w_top_s;
                    w_header_keep_nxt  = c_keep_all >> w_res_cnt;
                    w_header_valid_nxt = 1'b1;
                    w_residue_nxt      = w_low_r;
                    w_tail_cnt_nxt     = w_in_cnt - r_strip_cnt;
                    if (!last_in) begin
                        w_state_nxt = ST_STREAM;
                    end else if (w_in_cnt > r_strip_cnt) begin
                        w_state_nxt = ST_TAIL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            ST_STREAM: begin
                if (w_beat_acc) begin
                    w_valid_out_nxt = 1'b1;
                    w_data_out_nxt  = w_combined;
                    w_residue_nxt   = w_low_r;
                    w_tail_cnt_nxt  = w_in_cnt - r_strip_cnt;
                    if (!last_in || (w_in_cnt > r_strip_cnt)) begin
                        // Full beat; a last beat with leftover bytes spills into TAIL.
                        w_keep_out_nxt = c_keep_all;
                        w_last_out_nxt = 1'b0;
                        w_state_nxt    = last_in ? ST_TAIL : ST_STREAM;
                    end else begin
                        w_keep_out_nxt = c_keep_all << (c_nbytes - (w_res_cnt + w_in_cnt));
                        w_last_out_nxt = 1'b1;
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end

            ST_TAIL: begin
                if (w_out_adv) begin
                    w_valid_out_nxt = 1'b1;
                    w_data_out_nxt  = r_residue;
                    w_keep_out_nxt  = c_keep_all << (c_nbytes - r_tail_cnt);
                    w_last_out_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_strip_cnt  <= '0;
            r_residue    <= '0;
            r_tail_cnt   <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            header_out   <= '0;
            header_keep  <= '0;
            header_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_strip_cnt  <= w_strip_cnt_nxt;
            r_residue    <= w_residue_nxt;
            r_tail_cnt   <= w_tail_cnt_nxt;
            valid_out    <= w_valid_out_nxt;
            data_out     <= w_data_out_nxt;
            keep_out     <= w_keep_out_nxt;
            last_out     <= w_last_out_nxt;
            header_out   <= w_header_out_nxt;
            header_keep  <= w_header_keep_nxt;
            header_valid <= w_header_valid_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_strip_header.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_strip_header
// Description : Directed scoreboard bench for axi_stream_strip_header with
//               DATA_WD=32. Expected payload beats and headers are queued as
//               stimulus is issued and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_strip;
    logic [2:0]  byte_strip_cnt;
    logic        ready_strip;
    logic [31:0] header_out;
    logic [3:0]  header_keep;
    logic        header_valid;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_beat_q [$];
    logic [35:0] exp_hdr_q  [$];
    logic [36:0] m_beat;
    logic [35:0] m_hdr;

    axi_stream_strip_header #(
        .DATA_WD (32)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_strip    (valid_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .ready_strip    (ready_strip),
        .header_out     (header_out),
        .header_keep    (header_keep),
        .header_valid   (header_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_beat_q.push_back({d, k, l});
    endtask

    task automatic push_hdr(input logic [31:0] d, input logic [3:0] k);
        exp_hdr_q.push_back({d, k});
    endtask

    // All driving happens 1 time unit after a rising edge; ready signals are
    // sampled on the falling edge, where they are stable.
    task automatic send_strip(input logic [2:0] s);
        int   n;
        logic acc;
        n              = 0;
        acc            = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = s;
        do begin
            @(negedge clk);
            acc = ready_strip;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("strip_timeout", 64'(acc), 64'd1);
        valid_strip = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        do begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) check("beat_timeout", 64'(acc), 64'd1);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a beat is consumed when valid_out && ready_out.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            check("beat_expected", 64'(exp_beat_q.size() != 0), 64'd1);
            if (exp_beat_q.size() != 0) begin
                m_beat = exp_beat_q.pop_front();
                check("out_beat", 64'({data_out, keep_out, last_out}), 64'(m_beat));
            end
        end
        if (!rst && header_valid) begin
            check("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
            if (exp_hdr_q.size() != 0) begin
                m_hdr = exp_hdr_q.pop_front();
                check("header", 64'({header_out, header_keep}), 64'(m_hdr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;

        // Reset state
        @(negedge clk);
        check("rst_ctrl", 64'({valid_out, last_out, header_valid, ready_strip, ready_in}), 64'd0);
        check("rst_data", 64'({data_out, keep_out}), 64'd0);
        check("rst_hdr",  64'({header_out, header_keep}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // S=1, three beats, last beat has 2 valid bytes -> TAIL flush
        push_hdr(32'h000000AA, 4'b0001);
        push_beat(32'hBBCCDD11, 4'b1111, 1'b0);
        push_beat(32'h22334455, 4'b1111, 1'b0);
        push_beat(32'h66000000, 4'b1000, 1'b1);
        send_strip(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        idle(4);

        // S=3, last beat V=3 <= S -> single combined last beat, no TAIL
        push_hdr(32'h00AABBCC, 4'b0111);
        push_beat(32'hDD112233, 4'b1111, 1'b1);
        send_strip(3'd3);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1110, 1'b1);
        idle(4);

        // S=4, single beat -> header only
        push_hdr(32'hAABBCCDD, 4'b1111);
        send_strip(3'd4);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
        @(negedge clk);
        check("s4_ready_strip", 64'(ready_strip), 64'd1);
        check("s4_no_valid",    64'(valid_out),   64'd0);
        @(posedge clk);
        #1;
        idle(3);

        // S=0, data passes unchanged
        push_hdr(32'h00000000, 4'b0000);
        push_beat(32'h01020304, 4'b1111, 1'b0);
        push_beat(32'h05060708, 4'b1111, 1'b1);
        send_strip(3'd0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b1);
        idle(4);

        // S=1 with ready_out low for 3 cycles mid-packet
        push_hdr(32'h000000AA, 4'b0001);
        push_beat(32'hBBCCDD11, 4'b1111, 1'b0);
        push_beat(32'h22334455, 4'b1111, 1'b0);
        push_beat(32'h66000000, 4'b1000, 1'b1);
        send_strip(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        ready_out = 1'b0;
        valid_in  = 1'b1;
        data_in   = 32'h55667788;
        keep_in   = 4'b1100;
        last_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_data",     64'({data_out, keep_out, last_out}), 64'({32'hBBCCDD11, 4'b1111, 1'b0}));
            check("bp_valid",    64'(valid_out), 64'd1);
            check("bp_ready_in", 64'(ready_in),  64'd0);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        send_beat(32'h55667788, 4'b1100, 1'b1);
        idle(4);

        // Reset asserted while in STREAM with an output beat pending
        ready_out = 1'b0;
        push_hdr(32'h000000AA, 4'b0001);
        send_strip(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ctrl", 64'({valid_out, last_out, header_valid, ready_strip, ready_in}), 64'd0);
        check("mid_rst_data", 64'({data_out, keep_out}), 64'd0);
        check("mid_rst_hdr",  64'({header_out, header_keep}), 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ready_out = 1'b1;

        push_hdr(32'h000000AA, 4'b0001);
        push_beat(32'hBBCCDD11, 4'b1111, 1'b0);
        push_beat(32'h22334455, 4'b1111, 1'b0);
        push_beat(32'h66000000, 4'b1000, 1'b1);
        send_strip(3'd1);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        idle(6);

        check("beats_left",   64'(exp_beat_q.size()), 64'd0);
        check("headers_left", 64'(exp_hdr_q.size()),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WD, default 32, data bus width in bits.
- DATA_BYTE_WD, default DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), byte-count width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous reset, active high.
REQ-003 The block SHALL have these input stream ports:
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input beat; first byte in bits DATA_WD-1:DATA_WD-8.
- keep_in  in  DATA_BYTE_WD  byte enables; all ones except on the last beat, which is MSB-aligned.
- last_in  in  1  last beat of packet.
- ready_in  out  1  input beat accepted when valid_in and ready_in are both high.
REQ-004 The block SHALL have these output stream ports:
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  realigned payload beat.
- keep_out  out  DATA_BYTE_WD  byte enables; same alignment rules as keep_in.
- last_out  out  1  last payload beat.
- ready_out  in  1  downstream ready.
REQ-005 The block SHALL have these strip-control and header ports:
- valid_strip  in  1  strip command valid.
- byte_strip_cnt  in  BYTE_CNT_WD+1  header bytes to remove, range 0..DATA_BYTE_WD.
- ready_strip  out  1  strip command accepted.
- header_out  out  DATA_WD  removed header bytes, LSB-aligned.
- header_keep  out  DATA_BYTE_WD  enables for header_out, LSB-aligned, value {DATA_BYTE_WD{1}} >> (DATA_BYTE_WD-S).
- header_valid  out  1  one-cycle pulse when header_out is updated.

Function
REQ-006 The block SHALL run the FSM IDLE -> FIRST -> STREAM -> (TAIL) -> IDLE:
- IDLE: ready_strip=1 and ready_in=0; a strip handshake latches S=byte_strip_cnt and goes to FIRST.
- FIRST: the first input beat is accepted.
- STREAM: subsequent beats are accepted.
- TAIL: the residual beat is flushed and no input is accepted.
REQ-007 In FIRST, the block SHALL capture the top S bytes of data_in into header_out and pulse header_valid on the next cycle; header_valid SHALL pulse even when S=0, with header_keep=0.
REQ-008 The block SHALL hold the low R=DATA_BYTE_WD-S bytes of each accepted beat in a residue register.
REQ-009 Each output beat SHALL be {residue R bytes, top S bytes of the current input beat}, so payload byte order is preserved exactly.
REQ-010 On the last input beat with V valid bytes:
- V>S: emit the combined beat with last_out=0, then go to TAIL and emit the remaining V-S bytes MSB-aligned with last_out=1.
- V<=S: emit one beat of R+V bytes with last_out=1 and return to IDLE.
REQ-011 A single-beat packet with V<=S SHALL produce no output beat; only the header is emitted and the FSM returns to IDLE.
REQ-012 With S=DATA_BYTE_WD, the first beat SHALL be header only and later beats SHALL pass unshifted.
REQ-013 With S=0, data SHALL pass unchanged with one beat of buffering.
REQ-014 Outputs SHALL be registered; an output beat SHALL appear the cycle after the input beat that completes it is accepted.
REQ-015 Backpressure rules:
- ready_in = (state is FIRST or STREAM) and (!valid_out or ready_out).
- While valid_out=1 and ready_out=0, data_out, keep_out and last_out SHALL hold stable.
REQ-016 Sustained throughput SHALL be one beat per cycle while ready_out=1; the TAIL flush costs one extra cycle per packet.
REQ-017 keep_out SHALL be all ones on non-last beats and {DATA_BYTE_WD{1}} << (DATA_BYTE_WD-N) on the last beat, where N is the number of valid bytes.
REQ-018 valid_strip SHALL be ignored outside IDLE, and input beats SHALL be ignored in IDLE.

Reset
REQ-019 While rst=1, the block SHALL force: state=IDLE; valid_out, last_out, header_valid and ready_strip =0; data_out, keep_out, header_out and header_keep =0; residue cleared.
REQ-020 Assertion of rst mid-packet SHALL discard the partial packet immediately; after rst falls, the block SHALL accept a new strip command on the next cycle.

Verification
REQ-021 The bench SHALL cover, with DATA_WD=32:
- S=1; beats AABBCCDD, 11223344, 55667788 (keep 1100, last) -> header 000000AA/0001; out BBCCDD11, 22334455, 66000000/1000 last.
- S=3; beats AABBCCDD, 11223344 (keep 1110, last) -> header 00AABBCC/0111; out DD112233/1111 last; no TAIL beat.
- S=4; single beat AABBCCDD (keep 1111, last) -> header AABBCCDD/1111; no valid_out; ready_strip=1 the following cycle.
- S=0; two beats 01020304, 05060708 (keep 1111, last) -> identical output with last on 05060708; header_keep=0.
- S=1 stream with ready_out low for 3 cycles mid-packet -> data_out stable, ready_in=0, no byte lost or duplicated.
- rst pulsed in STREAM -> all outputs 0 next edge; the following S=1 packet is output correctly.
